mem_responder: RTL and testbench
================================

// Module: mem_responder
// PURPOSE
//  Memory-side responder for the multicycle RISC-V core's unified instruction/data memory.
//  Accepts one word request at a time from the core-side initiator over a valid/ready handshake.
//  Returns read data or a write acknowledge after a fixed, parameterised latency.
//  Lets the controller stall on memory instead of assuming a combinational array.
// PARAMETERS
//  DEPTH_WORDS  1024  number of 32-bit words in the array (power of two)
//  LATENCY      2     cycles from request acceptance to rsp_valid; legal range 1..15
// PORTS
//  clk        in   1   single clock, rising edge
//  rst        in   1   reset, asynchronous, active-low
//  req_valid  in   1   initiator presents a request
//  req_ready  out  1   responder can accept a request (high only in IDLE)
//  req_we     in   1   1 = write, 0 = read
//  req_addr   in   32  byte address; word index = req_addr[31:2]
//  req_wdata  in   32  write data
//  rsp_valid  out  1   response available
//  rsp_ready  in   1   initiator consumes response
//  rsp_rdata  out  32  read data; 0 for writes and errored requests
//  rsp_err    out  1   request was rejected (see CONFIGURATION)
// BEHAVIOUR
//  - Reset (rst low, async): state=IDLE, latency counter=0, rsp_valid=0, rsp_rdata=0, rsp_err=0.
//    req_ready=1 as soon as rst deasserts. Array contents are NOT reset.
//  - Reset mid-transaction: pending request dropped, no response issued.
//    A write already accepted remains committed.
//  - FSM states: IDLE, WAIT, RESP.
//  - IDLE: req_ready=1. Accept when req_valid&&req_ready.
//    - Write: commits to the array on the acceptance edge.
//    - Read: captures array[word] into the data register on the acceptance edge.
//    - Error flag is captured on the same edge.
//    - Next state: LATENCY==1 -> RESP, else WAIT with cnt=LATENCY-2.
//  - WAIT: req_ready=0. cnt decrements each cycle; at cnt==0 -> RESP.
//  - RESP: rsp_valid=1; rsp_rdata and rsp_err stable until handshake.
//    - rsp_valid&&rsp_ready -> IDLE; rsp_valid drops the next cycle.
//    - Stays in RESP indefinitely while rsp_ready=0.
//  - Timing: accept in cycle T -> rsp_valid first high in cycle T+LATENCY.
//  - No overlap: a new request cannot be accepted in the response-handshake cycle.
//    Minimum spacing between acceptances is LATENCY+1 cycles.
//  - Request inputs are sampled only at acceptance; later changes are ignored.
//  - Write responses: rsp_rdata=0. Errored requests: no array write, rsp_rdata=0, rsp_err=1.
//  - Reads after a write to the same word return the new data (write committed earlier).
//  - cnt is 4 bits wide and never underflows (reload only on acceptance).
// CONFIGURATION
//  - Macro MEM_ERR_CHECK_EN, when defined, flags an error (rsp_err=1) on either condition:
//    - misaligned access: req_addr[1:0]!=0
//    - out of range: req_addr[31:2] >= DEPTH_WORDS
//  - When undefined:
//    - req_addr[1:0] is ignored.
//    - Word index wraps modulo DEPTH_WORDS (upper bits dropped).
//    - rsp_err is tied to 0.
// TESTING
//  1 Reset: rst low mid-WAIT -> rsp_valid=0, req_ready=1 after release; earlier write to 0x10 still reads back.
//  2 Write 0xDEADBEEF @0x40, then read @0x40, LATENCY=2, rsp_ready=1
//    -> rsp_valid at T+2 each; read rsp_rdata=0xDEADBEEF, rsp_err=0.
//  3 Backpressure: read pending, rsp_ready=0 for 5 cycles
//    -> rsp_valid held, rsp_rdata stable, req_ready=0 and a new req_valid ignored.
//  4 LATENCY=1 back-to-back reads @0x0,@0x4 -> acceptances 2 cycles apart, responses in order.
//  5 MEM_ERR_CHECK_EN defined: write @0x42 and @(DEPTH_WORDS*4)
//    -> rsp_err=1, array unchanged (read @0x40 returns the old value).
//  6 MEM_ERR_CHECK_EN undefined: write 0x5 @(DEPTH_WORDS*4+8) -> read @0x8 returns 0x5, rsp_err=0.

Source files
------------

// File: rtl/mem_responder.sv
// Word-wide memory responder with fixed request-to-response latency over valid/ready.
// Define MEM_ERR_CHECK_EN to flag misaligned and out-of-range accesses via o_rsp_err.
module mem_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned LATENCY     = 2
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic        i_req_we,
    input  logic [31:0] i_req_addr,
    input  logic [31:0] i_req_wdata,
    output logic        o_rsp_valid,
    input  logic        i_rsp_ready,
    output logic [31:0] o_rsp_rdata,
    output logic        o_rsp_err
);

    localparam int unsigned AW = $clog2(DEPTH_WORDS);
    // WAIT spends LATENCY-1 cycles; counter counts down to zero before RESP.
    localparam logic [3:0] CNT_INIT = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

    state_e      r_state;
    logic [3:0]  r_cnt;
    logic        r_req_ready;
    logic        r_rsp_valid;
    logic [31:0] r_rdata;
    logic [31:0] r_mem [DEPTH_WORDS];

    logic          w_accept;
    logic          w_err;
    logic [AW-1:0] w_idx;

    assign w_accept = i_req_valid && r_req_ready;
    assign w_idx    = i_req_addr[AW+1:2];

`ifdef MEM_ERR_CHECK_EN
    logic r_err;
    assign w_err     = (i_req_addr[1:0] != 2'b00) || (i_req_addr[31:2] >= 30'(DEPTH_WORDS));
    assign o_rsp_err = r_err;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_err <= 1'b0;
        end else if (w_accept) begin
            r_err <= w_err;
        end else if (r_state == StResp && i_rsp_ready) begin
            r_err <= 1'b0;
        end
    end
`else
    logic w_unused_addr;
    assign w_unused_addr = ^{i_req_addr[31:AW+2], i_req_addr[1:0]};
    assign w_err         = 1'b0;
    assign o_rsp_err     = 1'b0;
`endif

    // Array is deliberately not reset; an accepted write commits on its acceptance edge.
    always_ff @(posedge i_clk) begin
        if (w_accept && i_req_we && !w_err) begin
            r_mem[w_idx] <= i_req_wdata;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= StIdle;
            r_cnt       <= 4'd0;
            r_req_ready <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rdata     <= 32'd0;
        end else begin
            case (r_state)
                StIdle: begin
                    if (w_accept) begin
                        r_rdata     <= (!i_req_we && !w_err) ? r_mem[w_idx] : 32'd0;
                        r_req_ready <= 1'b0;
                        if (LATENCY <= 1) begin
                            r_state     <= StResp;
                            r_rsp_valid <= 1'b1;
                        end else begin
                            r_state <= StWait;
                            r_cnt   <= CNT_INIT;
                        end
                    end
                end
                StWait: begin
                    if (r_cnt == 4'd0) begin
                        r_state     <= StResp;
                        r_rsp_valid <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                StResp: begin
                    if (i_rsp_ready) begin
                        r_state     <= StIdle;
                        r_rsp_valid <= 1'b0;
                        r_req_ready <= 1'b1;
                        r_rdata     <= 32'd0;
                    end
                end
                default: begin
                    r_state     <= StIdle;
                    r_rsp_valid <= 1'b0;
                    r_req_ready <= 1'b1;
                end
            endcase
        end
    end

    assign o_req_ready = r_req_ready;
    assign o_rsp_valid = r_rsp_valid;
    assign o_rsp_rdata = r_rdata;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: one instance with LATENCY=2, one with LATENCY=1.
// Shared request bus; w_sel picks which instance is driven and observed.
module tb_mem_responder;

    localparam int unsigned DEPTH = 1024;

    logic        clk;
    logic        rst_n;
    logic        sel;
    logic        req_valid;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_ready;

    logic        req_valid2, req_ready2, rsp_valid2, rsp_err2;
    logic        req_valid1, req_ready1, rsp_valid1, rsp_err1;
    logic [31:0] rsp_rdata2, rsp_rdata1;
    logic        w_req_ready, w_rsp_valid, w_rsp_err;
    logic [31:0] w_rsp_rdata;

    int n_checks;
    int n_fail;
    int cyc;

    assign req_valid2  = req_valid && !sel;
    assign req_valid1  = req_valid && sel;
    assign w_req_ready = sel ? req_ready1 : req_ready2;
    assign w_rsp_valid = sel ? rsp_valid1 : rsp_valid2;
    assign w_rsp_err   = sel ? rsp_err1 : rsp_err2;
    assign w_rsp_rdata = sel ? rsp_rdata1 : rsp_rdata2;

    mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(2)) u_dut2 (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_req_valid(req_valid2),
        .o_req_ready(req_ready2),
        .i_req_we   (req_we),
        .i_req_addr (req_addr),
        .i_req_wdata(req_wdata),
        .o_rsp_valid(rsp_valid2),
        .i_rsp_ready(rsp_ready && !sel),
        .o_rsp_rdata(rsp_rdata2),
        .o_rsp_err  (rsp_err2)
    );

    mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(1)) u_dut1 (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_req_valid(req_valid1),
        .o_req_ready(req_ready1),
        .i_req_we   (req_we),
        .i_req_addr (req_addr),
        .i_req_wdata(req_wdata),
        .o_rsp_valid(rsp_valid1),
        .i_rsp_ready(rsp_ready && sel),
        .o_rsp_rdata(rsp_rdata1),
        .o_rsp_err  (rsp_err1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // One full transaction; checks acceptance-to-rsp_valid latency and returns the response.
    task automatic xact(input logic s, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input int exp_lat, input string tag,
                        output logic [31:0] rdata, output logic err);
        int n;
        int lat;
        @(negedge clk);
        sel = s; req_we = we; req_addr = addr; req_wdata = wdata;
        req_valid = 1'b1; rsp_ready = 1'b1;
        n = 0;
        while (!w_req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1 req_valid = 1'b0;
        lat = 1;
        @(negedge clk);
        while (!w_rsp_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check_eq({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        rdata = w_rsp_rdata;
        err   = w_rsp_err;
        @(posedge clk);
        #1;
    endtask

    logic [31:0] rd;
    logic        er;
    int          t0;
    int          t1;

    initial begin
        n_checks = 0; n_fail = 0;
        sel = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
        rsp_ready = 1'b1;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk);
        check_eq("rst_req_ready", {31'd0, req_ready2}, 32'd1);
        check_eq("rst_rsp_valid", {31'd0, rsp_valid2}, 32'd0);
        check_eq("rst_rdata", rsp_rdata2, 32'd0);
        check_eq("rst_err", {31'd0, rsp_err2}, 32'd0);

        // Reset in the middle of WAIT drops the read; the earlier write survives.
        xact(1'b0, 1'b1, 32'h10, 32'h1234_5678, 2, "t1_wr", rd, er);
        @(negedge clk);
        sel = 1'b0; req_we = 1'b0; req_addr = 32'h10; req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk) rst_n = 1'b0;
        #1 check_eq("t1_valid_in_rst", {31'd0, rsp_valid2}, 32'd0);
        @(negedge clk) rst_n = 1'b1;
        check_eq("t1_ready_after", {31'd0, req_ready2}, 32'd1);
        repeat (3) @(negedge clk);
        check_eq("t1_no_rsp", {31'd0, rsp_valid2}, 32'd0);
        xact(1'b0, 1'b0, 32'h10, 32'h0, 2, "t1_rd", rd, er);
        check_eq("t1_rd_data", rd, 32'h1234_5678);

        // Write then read back with LATENCY=2.
        xact(1'b0, 1'b1, 32'h40, 32'hDEAD_BEEF, 2, "t2_wr", rd, er);
        check_eq("t2_wr_data", rd, 32'd0);
        xact(1'b0, 1'b0, 32'h40, 32'h0, 2, "t2_rd", rd, er);
        check_eq("t2_rd_data", rd, 32'hDEAD_BEEF);
        check_eq("t2_rd_err", {31'd0, er}, 32'd0);
        @(negedge clk);
        check_eq("t2_valid_drop", {31'd0, rsp_valid2}, 32'd0);

        // Backpressure: response held, competing write must not be accepted.
        sel = 1'b0; rsp_ready = 1'b0; req_we = 1'b0; req_addr = 32'h40; req_valid = 1'b1;
        @(posedge clk);
        #1 req_we = 1'b1; req_wdata = 32'h0000_0BAD;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            check_eq("t3_valid", {31'd0, rsp_valid2}, 32'd1);
            check_eq("t3_rdata", rsp_rdata2, 32'hDEAD_BEEF);
            check_eq("t3_ready", {31'd0, req_ready2}, 32'd0);
            @(negedge clk);
        end
        req_valid = 1'b0; rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        xact(1'b0, 1'b0, 32'h40, 32'h0, 2, "t3_rd", rd, er);
        check_eq("t3_unchanged", rd, 32'hDEAD_BEEF);

        // LATENCY=1 back-to-back reads: acceptances two cycles apart, in order.
        xact(1'b1, 1'b1, 32'h0, 32'h0000_0011, 1, "t4_wr0", rd, er);
        xact(1'b1, 1'b1, 32'h4, 32'h0000_0022, 1, "t4_wr1", rd, er);
        @(negedge clk);
        sel = 1'b1; req_we = 1'b0; req_addr = 32'h0; req_valid = 1'b1; rsp_ready = 1'b1;
        @(posedge clk);
        #1 t0 = cyc; req_addr = 32'h4;
        @(negedge clk);
        check_eq("t4_rsp0", rsp_rdata1, 32'h0000_0011);
        check_eq("t4_busy", {31'd0, req_ready1}, 32'd0);
        @(negedge clk);
        check_eq("t4_ready", {31'd0, req_ready1}, 32'd1);
        @(posedge clk);
        #1 t1 = cyc; req_valid = 1'b0;
        check_eq("t4_spacing", 32'(t1 - t0), 32'd2);
        @(negedge clk);
        check_eq("t4_rsp1_valid", {31'd0, rsp_valid1}, 32'd1);
        check_eq("t4_rsp1", rsp_rdata1, 32'h0000_0022);
        @(posedge clk);
        #1;

`ifdef MEM_ERR_CHECK_EN
        xact(1'b0, 1'b1, 32'h42, 32'h1111_1111, 2, "t5_mis", rd, er);
        check_eq("t5_mis_err", {31'd0, er}, 32'd1);
        xact(1'b0, 1'b1, DEPTH * 4, 32'h2222_2222, 2, "t5_oor", rd, er);
        check_eq("t5_oor_err", {31'd0, er}, 32'd1);
        check_eq("t5_oor_data", rd, 32'd0);
        xact(1'b0, 1'b0, 32'h40, 32'h0, 2, "t5_rd", rd, er);
        check_eq("t5_rd_data", rd, 32'hDEAD_BEEF);
        check_eq("t5_rd_err", {31'd0, er}, 32'd0);
`else
        xact(1'b0, 1'b1, DEPTH * 4 + 8, 32'h5, 2, "t6_wr", rd, er);
        check_eq("t6_wr_err", {31'd0, er}, 32'd0);
        xact(1'b0, 1'b0, 32'h8, 32'h0, 2, "t6_rd", rd, er);
        check_eq("t6_rd_data", rd, 32'h5);
        check_eq("t6_rd_err", {31'd0, er}, 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
